// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared Mini-CPU encodings (state, opcode) and the instruction
//            field decoder used by the control stage.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_OFF     = 3'b000,
      ST_FETCH   = 3'b001,
      ST_DECODE  = 3'b010,
      ST_READ    = 3'b011,
      ST_CALC    = 3'b100,
      ST_DISPLAY = 3'b101,
      ST_STORE   = 3'b110
   } cpu_state_t;

   typedef enum logic [2:0] {
      OP_LOAD    = 3'b000,
      OP_ADD     = 3'b001,
      OP_ADDI    = 3'b010,
      OP_SUB     = 3'b011,
      OP_SUBI    = 3'b100,
      OP_MUL     = 3'b101,
      OP_CLEAR   = 3'b110,
      OP_DISPLAY = 3'b111
   } opcode_t;

   typedef struct packed {
      opcode_t     op;
      logic [3:0]  a1;
      logic [3:0]  a2;
      logic [3:0]  a3;
      logic [15:0] imm;
   } decoded_t;

   // Splits an instruction word into the fields its opcode actually uses;
   // fields an opcode does not use are returned as zero.
   function automatic decoded_t decode_instr(input logic [15:0] instr);
      decoded_t d;
      d     = '0;
      d.op  = opcode_t'(instr[15:13]);
      d.a1  = instr[12:9];
      case (d.op)
         OP_LOAD:                  d.imm = {{7{instr[8]}}, instr[8:0]};
         OP_ADDI, OP_SUBI, OP_MUL: begin
            d.a2  = instr[8:5];
            d.imm = {{11{instr[4]}}, instr[4:0]};
         end
         OP_ADD, OP_SUB: begin
            d.a2 = instr[8:5];
            d.a3 = instr[4:1];
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_control_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_if
// Purpose  : User/memory facing signal bundle of the control stage.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_control_if;
   import cpu_pkg::*;

   logic        power;
   logic        send;
   logic [15:0] instr;
   logic        read_ack;
   logic        store_ack;
   cpu_state_t  state;
   opcode_t     opcode;
   logic [3:0]  addr1;
   logic [3:0]  addr2;
   logic [3:0]  addr3;
   logic [15:0] imm;
   logic        busy;
   logic        err;
   logic [7:0]  instr_count;

   // Environment side: drives user controls and memory acknowledges.
   modport master (
      output power, send, instr, read_ack, store_ack,
      input  state, opcode, addr1, addr2, addr3, imm, busy, err, instr_count
   );

   // Control stage side.
   modport slave (
      input  power, send, instr, read_ack, store_ack,
      output state, opcode, addr1, addr2, addr3, imm, busy, err, instr_count
   );

endinterface
`default_nettype wire

// File: rtl/cpu_control_btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge
// Purpose  : Rising-edge detector for the synchronous send button; a held
//            button yields a single one-cycle request.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_btn,
   output logic      o_rise
);

   logic r_prev;

   // Remember last cycle's button level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_prev <= 1'b0;
      else        r_prev <= i_btn;
   end

   assign o_rise = i_btn & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/cpu_control.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control
// Purpose  : Mini-CPU control/decode stage: captures an instruction on a
//            send edge, decodes it and sequences the CPU state with
//            acknowledge timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control
   import cpu_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15,
   parameter int DISP_CYCLES = 4
) (
   input wire logic     clk,
   input wire logic     rst_n,
   cpu_control_if.slave bus
);

   // One counter serves both the acknowledge wait and the display hold.
   localparam int CNT_MAX = (ACK_TIMEOUT > DISP_CYCLES) ? ACK_TIMEOUT : DISP_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   cpu_state_t  r_state;
   opcode_t     r_op;
   logic [3:0]  r_a1, r_a2, r_a3;
   logic [15:0] r_imm;
   logic        r_err;
   logic [7:0]  r_count;
   logic [CNT_W-1:0] r_cnt;

   logic     w_req;
   decoded_t w_dec;

   btn_edge u_btn_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (bus.send),
      .o_rise (w_req)
   );

   assign w_dec = decode_instr(bus.instr);

   // Main sequencer; power loss overrides every other event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_OFF;
         r_op    <= OP_LOAD;
         r_a1    <= '0;
         r_a2    <= '0;
         r_a3    <= '0;
         r_imm   <= '0;
         r_err   <= 1'b0;
         r_count <= '0;
         r_cnt   <= '0;
      end else if (!bus.power) begin
         r_state <= ST_OFF;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_OFF: r_state <= ST_FETCH;
            ST_FETCH: begin
               r_cnt <= '0;
               if (w_req) begin
                  r_op    <= w_dec.op;
                  r_a1    <= w_dec.a1;
                  r_a2    <= w_dec.a2;
                  r_a3    <= w_dec.a3;
                  r_imm   <= w_dec.imm;
                  r_err   <= 1'b0;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_cnt   <= '0;
               r_state <= (r_op == OP_LOAD || r_op == OP_CLEAR) ? ST_CALC : ST_READ;
            end
            ST_READ: begin
               if (bus.read_ack) begin
                  r_cnt   <= '0;
                  r_state <= ST_CALC;
               end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                  r_cnt   <= '0;
                  r_err   <= 1'b1;
                  r_state <= ST_FETCH;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_CALC: begin
               r_cnt   <= '0;
               r_state <= (r_op == OP_DISPLAY) ? ST_DISPLAY : ST_STORE;
            end
            ST_STORE: begin
               if (bus.store_ack) begin
                  r_cnt   <= '0;
                  r_state <= ST_DISPLAY;
               end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                  r_cnt   <= '0;
                  r_err   <= 1'b1;
                  r_state <= ST_FETCH;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DISPLAY: begin
               if (r_cnt == CNT_W'(DISP_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_count <= r_count + 8'd1;
                  r_state <= ST_FETCH;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= ST_OFF;
            end
         endcase
      end
   end

   assign bus.state       = r_state;
   assign bus.opcode      = r_op;
   assign bus.addr1       = r_a1;
   assign bus.addr2       = r_a2;
   assign bus.addr3       = r_a3;
   assign bus.imm         = r_imm;
   assign bus.err         = r_err;
   assign bus.instr_count = r_count;
   assign bus.busy        = (r_state != ST_OFF) && (r_state != ST_FETCH);

endmodule
`default_nettype wire

// File: tb/tb_cpu_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control
// Purpose  : Directed self-checking bench for cpu_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control;
   import cpu_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   cpu_control_if bus ();

   cpu_control #(.ACK_TIMEOUT(15), .DISP_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string name, input cpu_state_t exp);
      checks++;
      if (bus.state !== exp) begin
         errors++;
         $display("FAIL %s: state got %0d want %0d", name, bus.state, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.power = 1'b0; bus.send = 1'b0; bus.instr = '0;
      bus.read_ack = 1'b0; bus.store_ack = 1'b0;
      step(); step();
      expect_state("reset_state", ST_OFF);
      checks++;
      if ({bus.opcode, bus.addr1, bus.addr2, bus.addr3, bus.imm, bus.busy, bus.err, bus.instr_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: op=%0d a1=%0d a2=%0d a3=%0d imm=%h busy=%b err=%b cnt=%0d want all 0",
                  bus.opcode, bus.addr1, bus.addr2, bus.addr3, bus.imm, bus.busy, bus.err, bus.instr_count);
      end
      rst_n = 1'b1; bus.power = 1'b1;
      step();
      expect_state("power_on_fetch", ST_FETCH);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL fetch_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_add();
      bus.instr = 16'h2A0F; bus.send = 1'b1;
      step(); bus.send = 1'b0;
      expect_state("add_decode", ST_DECODE);
      checks++;
      if (bus.opcode !== OP_ADD || bus.addr1 !== 4'd5 || bus.addr2 !== 4'd0 || bus.addr3 !== 4'd7 || bus.imm !== 16'h0) begin
         errors++;
         $display("FAIL add_fields: op=%0d a1=%0d a2=%0d a3=%0d imm=%h want 1/5/0/7/0000",
                  bus.opcode, bus.addr1, bus.addr2, bus.addr3, bus.imm);
      end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %b want 1", bus.busy); end
      step(); expect_state("add_read1", ST_READ);
      step(); expect_state("add_read2", ST_READ);
      bus.read_ack = 1'b1;
      step(); expect_state("add_calc", ST_CALC);
      bus.read_ack = 1'b0; bus.store_ack = 1'b1;
      step(); expect_state("add_store", ST_STORE);
      step(); bus.store_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_state("add_display", ST_DISPLAY);
         step();
      end
      expect_state("add_fetch", ST_FETCH);
      checks++;
      if (bus.instr_count !== 8'd1) begin errors++; $display("FAIL add_count: got %0d want 1", bus.instr_count); end
   endtask

   task automatic test_load();
      bus.instr = 16'h03FF; bus.send = 1'b1;
      step(); bus.send = 1'b0;
      expect_state("load_decode", ST_DECODE);
      checks++;
      if (bus.opcode !== OP_LOAD || bus.addr1 !== 4'd1 || bus.addr2 !== 4'd0 || bus.addr3 !== 4'd0 || bus.imm !== 16'hFFFF) begin
         errors++;
         $display("FAIL load_fields: op=%0d a1=%0d a2=%0d a3=%0d imm=%h want 0/1/0/0/ffff",
                  bus.opcode, bus.addr1, bus.addr2, bus.addr3, bus.imm);
      end
      step(); expect_state("load_calc", ST_CALC);
      bus.store_ack = 1'b1;
      step(); expect_state("load_store", ST_STORE);
      step(); bus.store_ack = 1'b0;
      for (int i = 0; i < 4; i++) step();
      expect_state("load_fetch", ST_FETCH);
      checks++;
      if (bus.instr_count !== 8'd2) begin errors++; $display("FAIL load_count: got %0d want 2", bus.instr_count); end
   endtask

   task automatic test_display();
      bus.instr = 16'hE600; bus.send = 1'b1; bus.read_ack = 1'b1; bus.store_ack = 1'b1;
      step(); bus.send = 1'b0;
      expect_state("disp_decode", ST_DECODE);
      checks++;
      if (bus.opcode !== OP_DISPLAY || bus.addr1 !== 4'd3 || bus.addr2 !== 4'd0 || bus.imm !== 16'h0) begin
         errors++;
         $display("FAIL disp_fields: op=%0d a1=%0d a2=%0d imm=%h want 7/3/0/0000", bus.opcode, bus.addr1, bus.addr2, bus.imm);
      end
      step(); expect_state("disp_read", ST_READ);
      step(); expect_state("disp_calc", ST_CALC);
      for (int i = 0; i < 4; i++) begin
         step(); expect_state("disp_hold", ST_DISPLAY);
      end
      step(); expect_state("disp_fetch", ST_FETCH);
      bus.read_ack = 1'b0; bus.store_ack = 1'b0;
      checks++;
      if (bus.instr_count !== 8'd3) begin errors++; $display("FAIL disp_count: got %0d want 3", bus.instr_count); end
   endtask

   task automatic test_timeout();
      bus.instr = 16'h2A0F; bus.send = 1'b1;
      step(); bus.send = 1'b0;
      expect_state("to_decode", ST_DECODE);
      for (int i = 0; i < 15; i++) begin
         step(); expect_state("to_read_wait", ST_READ);
      end
      step(); expect_state("to_fetch", ST_FETCH);
      checks++;
      if (bus.err !== 1'b1 || bus.instr_count !== 8'd3) begin
         errors++;
         $display("FAIL to_err: err=%b cnt=%0d want 1/3", bus.err, bus.instr_count);
      end
      // ADDI a1=5 a2=3 imm5=01010 clears the sticky error
      bus.instr = 16'h4A6A; bus.send = 1'b1; bus.read_ack = 1'b1; bus.store_ack = 1'b1;
      step(); bus.send = 1'b0;
      checks++;
      if (bus.err !== 1'b0 || bus.opcode !== OP_ADDI || bus.addr1 !== 4'd5 || bus.addr2 !== 4'd3 ||
          bus.addr3 !== 4'd0 || bus.imm !== 16'h000A) begin
         errors++;
         $display("FAIL addi_fields: err=%b op=%0d a1=%0d a2=%0d a3=%0d imm=%h want 0/2/5/3/0/000a",
                  bus.err, bus.opcode, bus.addr1, bus.addr2, bus.addr3, bus.imm);
      end
      for (int i = 0; i < 8; i++) step();
      expect_state("addi_fetch", ST_FETCH);
      checks++;
      if (bus.instr_count !== 8'd4) begin errors++; $display("FAIL addi_count: got %0d want 4", bus.instr_count); end
   endtask

   task automatic test_held_send();
      bus.instr = 16'h2A0F; bus.send = 1'b1; bus.read_ack = 1'b1; bus.store_ack = 1'b1;
      for (int i = 0; i < 20; i++) step();
      expect_state("held_fetch", ST_FETCH);
      checks++;
      if (bus.instr_count !== 8'd5) begin errors++; $display("FAIL held_count: got %0d want 5", bus.instr_count); end
      bus.send = 1'b0;
      step();
   endtask

   task automatic test_power_store();
      bus.instr = 16'h2A0F; bus.send = 1'b1; bus.read_ack = 1'b1; bus.store_ack = 1'b0;
      step(); bus.send = 1'b0;
      step(); step(); step();
      expect_state("pwr_store", ST_STORE);
      bus.power = 1'b0; bus.store_ack = 1'b1;
      step();
      expect_state("pwr_off", ST_OFF);
      checks++;
      if (bus.busy !== 1'b0 || bus.addr1 !== 4'd5 || bus.addr3 !== 4'd7 || bus.instr_count !== 8'd5) begin
         errors++;
         $display("FAIL pwr_hold: busy=%b a1=%0d a3=%0d cnt=%0d want 0/5/7/5", bus.busy, bus.addr1, bus.addr3, bus.instr_count);
      end
      bus.power = 1'b1; bus.read_ack = 1'b0; bus.store_ack = 1'b0;
      step();
      expect_state("pwr_refetch", ST_FETCH);
   endtask

   task automatic test_reset_calc();
      bus.instr = 16'h03FF; bus.send = 1'b1;
      step(); bus.send = 1'b0;
      step();
      expect_state("rst_calc", ST_CALC);
      #2 rst_n = 1'b0;
      #1;
      expect_state("rst_async_off", ST_OFF);
      checks++;
      if (bus.instr_count !== 8'd0 || bus.addr1 !== 4'd0 || bus.imm !== 16'h0) begin
         errors++;
         $display("FAIL rst_async_clear: cnt=%0d a1=%0d imm=%h want 0/0/0000", bus.instr_count, bus.addr1, bus.imm);
      end
      step();
      rst_n = 1'b1;
      step();
      expect_state("rst_refetch", ST_FETCH);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_load();
      test_display();
      test_timeout();
      test_held_send();
      test_power_store();
      test_reset_calc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Control and decode stage of the Mini-CPU; sits directly upstream of the register memory bank.
- Captures a 16-bit instruction word when the user presses "send" and decodes it into opcode, addresses and a sign-extended immediate.
- Sequences the CPU state (OFF/FETCH/DECODE/READ/CALC/DISPLAY/STORE) that memory and ALU consume, advancing on memory's read/stored acknowledgements with a timeout guard.

Parameters:
- ACK_TIMEOUT, 15, max cycles to wait in READ or STORE for an acknowledge before aborting.
- DISP_CYCLES, 4, cycles the DISPLAY state is held (minimum 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- power  in  1  level; 0 forces OFF
- send  in  1  user execute button, synchronous level; a rising edge requests an instruction
- instr  in  16  instruction word: [15:13] opcode, [12:9] a1, [8:5] a2, [4:1] a3, [4:0] imm5
- read_ack  in  1  memory "read" flag
- store_ack  in  1  memory "stored" flag
- state  out  3  CPU state: OFF=000 FETCH=001 DECODE=010 READ=011 CALC=100 DISPLAY=101 STORE=110
- opcode  out  3  LOAD=000 ADD=001 ADDI=010 SUB=011 SUBI=100 MUL=101 CLEAR=110 DISPLAY=111
- addr1, addr2, addr3  out  4 each  decoded address fields
- imm  out  16  immediate, sign-extended
- busy  out  1  high in every state except OFF and FETCH
- err  out  1  sticky acknowledge-timeout flag
- instr_count  out  8  count of completed instructions

Behaviour:
- Reset (async, rst_n=0): state=OFF; opcode, addr1-3, imm, err, instr_count = 0; busy=0; edge detector history cleared. Reset mid-instruction aborts it with no trace.
- power=0 in any state: next edge state=OFF; outputs are not cleared except busy=0. OFF with power=1: next edge goes to FETCH.
- Edge detect: send_prev registered; a request is send & ~send_prev. A held button is one request. Edges seen outside FETCH are dropped.
- FETCH, on a request: latch instr fields, clear err, go to DECODE. Field decode per opcode:
  - LOAD: addr1=[12:9], imm = sign-extend of [8:0].
  - ADDI/SUBI/MUL: addr1=[12:9], addr2=[8:5], imm = sign-extend of [4:0].
  - ADD/SUB: addr1, addr2, addr3 from [12:9], [8:5], [4:1].
  - CLEAR/DISPLAY: addr1=[12:9].
  - Unused address outputs are 0 and imm=0 where not applicable.
- DECODE: 1 cycle. LOAD and CLEAR go to CALC; all others go to READ.
- READ: wait for read_ack=1, then go to CALC. The wait counter resets on entry. If ACK_TIMEOUT cycles elapse with no ack: err=1, go to FETCH, instr_count not incremented.
- CALC: 1 cycle. DISPLAY opcode goes to DISPLAY; all others go to STORE.
- STORE: wait for store_ack=1, then go to DISPLAY. Timeout handling is identical to READ.
- DISPLAY: hold exactly DISP_CYCLES cycles, then go to FETCH with instr_count+1. instr_count wraps 255->0.
- Minimum latency, request edge to FETCH return:
  - ADD with ack on the 2nd READ cycle and the 2nd STORE cycle: 1 DECODE + 2 READ + 1 CALC + 2 STORE + DISP_CYCLES.
- Simultaneous events:
  - power=0 has priority over ack and timeout.
  - An ack arriving on the timeout cycle counts as success.
- Decoded fields remain stable from DECODE until the next accepted request.

Decomposition:
- Package cpu_pkg holds the state encodings and opcode encodings. memory and the ALU import the same package; the state width is 3 bits everywhere.
- One sub-module, btn_edge: registered rising-edge detector with async active-low reset.

Test Plan:
- Reset, then power=1 -> state=FETCH on the next edge; all outputs 0; busy=0.
- instr=0x2A0F (ADD a1=5, a2=0, a3=7), send pulse, read_ack on 2nd READ cycle, store_ack on 1st STORE cycle -> state sequence DECODE, READ, READ, CALC, STORE, DISPLAYx4, FETCH; addr1=5, addr2=0, addr3=7; instr_count=1.
- LOAD instr=0x03FF (a1=1, imm9=0x1FF) -> imm=0xFFFF; READ skipped; state sequence DECODE, CALC, STORE.
- DISPLAY opcode instr=0xE600 -> addr1=3; sequence DECODE, READ, CALC, DISPLAY; STORE never entered.
- READ with no read_ack -> after 15 cycles err=1, state=FETCH, instr_count unchanged; next accepted request clears err.
- send held high for 20 cycles -> exactly one instruction executed.
- power dropped during STORE -> state=OFF next edge.
- rst_n asserted during CALC -> state=OFF immediately, without waiting for a clock edge.
